// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its frame filter.
package keypad_pkg;

  typedef enum logic {RELEASED, PRESSED} kp_state_t;

  typedef enum logic [1:0] {FR_NONE, FR_ONE, FR_MULTI} frame_class_t;

  function automatic int unsigned kp_code(input int unsigned row, input int unsigned col,
                                          input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_frame_filter.sv
// Frame-level debounce filter: tracks the candidate frame class/code and how many consecutive
// frames have matched it, strobing once when the candidate first becomes stable.
module keypad_frame_filter
  import keypad_pkg::*;
#(
  parameter int unsigned DB_FRAMES = 4,
  parameter int unsigned KW        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_valid_i,
  input  frame_class_t frame_class_i,
  input  logic [KW-1:0] frame_code_i,
  output frame_class_t stable_class_o,
  output logic [KW-1:0] stable_code_o,
  output logic         stable_o
);

  localparam int unsigned SW = $clog2(DB_FRAMES + 1);
  localparam logic [SW-1:0] StabMax = SW'(DB_FRAMES);

  frame_class_t  cand_class_q, cand_class_d;
  logic [KW-1:0] cand_code_q, cand_code_d;
  logic [SW-1:0] stab_cnt_q, stab_cnt_d;
  logic          changed;

  always_comb begin
    cand_class_d = cand_class_q;
    cand_code_d  = cand_code_q;
    stab_cnt_d   = stab_cnt_q;
    stable_o     = 1'b0;
    changed      = (frame_class_i != cand_class_q) ||
                   ((frame_class_i == FR_ONE) && (frame_code_i != cand_code_q));
    if (frame_valid_i) begin
      cand_class_d = frame_class_i;
      cand_code_d  = frame_code_i;
      if (frame_class_i == FR_MULTI) begin
        stab_cnt_d = '0;
      end else if (changed) begin
        stab_cnt_d = SW'(1);
      end else if (stab_cnt_q != StabMax) begin
        stab_cnt_d = stab_cnt_q + 1'b1;
      end
      // Fire only on the frame that reaches the threshold, not while it stays saturated.
      stable_o = (stab_cnt_d == StabMax) && (changed || (stab_cnt_q != StabMax));
    end
  end

  assign stable_class_o = cand_class_d;
  assign stable_code_o  = cand_code_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_class_q <= FR_NONE;
      cand_code_q  <= '0;
      stab_cnt_q   <= '0;
    end else begin
      cand_class_q <= cand_class_d;
      cand_code_q  <= cand_code_d;
      stab_cnt_q   <= stab_cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Row-scanning keypad controller: synchronises columns, classifies each scan frame, debounces
// in whole frames and hands one encoded event per press to the consumer over valid/ready.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  parameter int unsigned SCAN_DIV  = 16,
  parameter int unsigned DB_FRAMES = 4,
  localparam int unsigned KW       = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [COLS-1:0] columnas,
  output logic [ROWS-1:0] row_drive,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic            key_held,
  output logic            multi_key,
  output logic            overrun
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam logic [DW-1:0] DivLast = DW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);

  // Column synchroniser
  logic [COLS-1:0] col_meta_q, col_sync_q;

  // Scan counters
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [ROWS-1:0] row_drive_q, row_drive_d;

  // Frame accumulation
  logic [1:0]    acc_hits_q, acc_hits_d;
  logic [KW-1:0] acc_code_q, acc_code_d;
  logic [1:0]    row_hits;
  logic [CW-1:0] row_col;
  logic [2:0]    hit_sum;
  logic [1:0]    tot_hits;
  logic [KW-1:0] tot_code;
  logic          sample, frame_end;
  frame_class_t  frame_class;

  // Filter outputs
  frame_class_t  stab_class;
  logic [KW-1:0] stab_code;
  logic          stab_strobe;

  // Event FSM and handshake
  kp_state_t     state_q, state_d;
  logic          key_valid_q, key_valid_d;
  logic [KW-1:0] key_code_q, key_code_d;
  logic          key_held_q, key_held_d;
  logic          multi_key_q, multi_key_d;
  logic          overrun_q, overrun_d;
  logic          accept;

  always_comb begin
    div_cnt_d   = div_cnt_q + 1'b1;
    row_idx_d   = row_idx_q;
    row_drive_d = row_drive_q;
    if (div_cnt_q == DivLast) begin
      div_cnt_d   = '0;
      row_idx_d   = (row_idx_q == RowLast) ? '0 : row_idx_q + 1'b1;
      row_drive_d = {row_drive_q[ROWS-2:0], row_drive_q[ROWS-1]};
    end
  end

  // Hit count (saturating at two) and lowest set column for the driven row.
  always_comb begin
    row_hits = 2'd0;
    row_col  = '0;
    for (int c = int'(COLS) - 1; c >= 0; c--) begin
      if (col_sync_q[c]) begin
        row_col = CW'(c);
        if (row_hits != 2'd2) begin
          row_hits = row_hits + 2'd1;
        end
      end
    end
  end

  assign sample    = (div_cnt_q == DivLast);
  assign frame_end = sample && (row_idx_q == RowLast);
  assign hit_sum   = {1'b0, acc_hits_q} + {1'b0, row_hits};
  assign tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
  assign tot_code  = (acc_hits_q == 2'd0) ?
                     KW'(kp_code(32'(row_idx_q), 32'(row_col), COLS)) : acc_code_q;

  always_comb begin
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      acc_hits_d = frame_end ? 2'd0 : tot_hits;
      acc_code_d = frame_end ? '0 : tot_code;
    end
  end

  always_comb begin
    unique case (tot_hits)
      2'd0:    frame_class = FR_NONE;
      2'd1:    frame_class = FR_ONE;
      default: frame_class = FR_MULTI;
    endcase
  end

  keypad_frame_filter #(
    .DB_FRAMES (DB_FRAMES),
    .KW        (KW)
  ) u_filter (
    .clk            (clk),
    .reset          (reset),
    .frame_valid_i  (frame_end),
    .frame_class_i  (frame_class),
    .frame_code_i   (tot_code),
    .stable_class_o (stab_class),
    .stable_code_o  (stab_code),
    .stable_o       (stab_strobe)
  );

  assign accept = key_valid_q & key_ready;

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    overrun_d   = 1'b0;

    if (accept) begin
      key_valid_d = 1'b0;
    end
    if (frame_end) begin
      multi_key_d = (frame_class == FR_MULTI);
    end

    if (stab_strobe) begin
      unique case (state_q)
        RELEASED: begin
          if (stab_class == FR_ONE) begin
            state_d    = PRESSED;
            key_held_d = 1'b1;
            // A slot freed by this cycle's acceptance can take the new event directly.
            if (!key_valid_q || accept) begin
              key_valid_d = 1'b1;
              key_code_d  = stab_code;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        PRESSED: begin
          if (stab_class == FR_NONE) begin
            state_d    = RELEASED;
            key_held_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_meta_q  <= '0;
      col_sync_q  <= '0;
      div_cnt_q   <= '0;
      row_idx_q   <= '0;
      row_drive_q <= ROWS'(1);
      acc_hits_q  <= '0;
      acc_code_q  <= '0;
      state_q     <= RELEASED;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      col_meta_q  <= columnas;
      col_sync_q  <= col_meta_q;
      div_cnt_q   <= div_cnt_d;
      row_idx_q   <= row_idx_d;
      row_drive_q <= row_drive_d;
      acc_hits_q  <= acc_hits_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row_drive = row_drive_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: default 4x4 instance plus a 2x8, one-frame sweep.
module tb_keypad_scan_debounce;

  localparam int FRAME  = 64;
  localparam int FRAME2 = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0] columnas;
  logic [3:0] row_drive;
  logic       key_valid, key_ready = 1'b0;
  logic [3:0] key_code;
  logic       key_held, multi_key, overrun;

  logic [15:0] keys2 = '0;
  logic [7:0] columnas2;
  logic [1:0] row_drive2;
  logic       key_valid2, key_ready2 = 1'b1;
  logic [3:0] key_code2;
  logic       key_held2, multi_key2, overrun2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Matrix model: a column reads high when a pressed key sits on a driven row.
  always_comb begin
    columnas = '0;
    for (int r = 0; r < 4; r++) if (row_drive[r]) columnas = columnas | keys[r*4 +: 4];
  end

  always_comb begin
    columnas2 = '0;
    for (int r = 0; r < 2; r++) if (row_drive2[r]) columnas2 = columnas2 | keys2[r*8 +: 8];
  end

  keypad_scan_debounce u_dut (
    .clk       (clk),
    .reset     (reset),
    .columnas  (columnas),
    .row_drive (row_drive),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_code  (key_code),
    .key_held  (key_held),
    .multi_key (multi_key),
    .overrun   (overrun)
  );

  keypad_scan_debounce #(
    .ROWS      (2),
    .COLS      (8),
    .SCAN_DIV  (4),
    .DB_FRAMES (1)
  ) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .columnas  (columnas2),
    .row_drive (row_drive2),
    .key_valid (key_valid2),
    .key_ready (key_ready2),
    .key_code  (key_code2),
    .key_held  (key_held2),
    .multi_key (multi_key2),
    .overrun   (overrun2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!key_valid && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    key_ready = 1'b0;
    keys = '0;
    do_reset();
    total++; if (row_drive !== 4'b0001) $display("FAIL reset_row_drive got %b want 0001", row_drive); else passed++;
    total++; if (key_valid !== 1'b0) $display("FAIL reset_key_valid got %b want 0", key_valid); else passed++;
    total++; if (key_code !== 4'd0) $display("FAIL reset_key_code got %0d want 0", key_code); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL reset_key_held got %b want 0", key_held); else passed++;
    total++; if (multi_key !== 1'b0) $display("FAIL reset_multi_key got %b want 0", multi_key); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
  endtask

  task automatic test_scan();
    repeat (15) tick();
    total++; if (row_drive !== 4'b0001) $display("FAIL scan_row0_hold got %b want 0001", row_drive); else passed++;
    tick();
    total++; if (row_drive !== 4'b0010) $display("FAIL scan_row1 got %b want 0010", row_drive); else passed++;
    repeat (48) tick();
    total++; if (row_drive !== 4'b0001) $display("FAIL scan_wrap got %b want 0001", row_drive); else passed++;
  endtask

  task automatic test_single_press();
    int cyc;
    int events;
    key_ready = 1'b0;
    do_reset();
    keys = 16'h0200;
    wait_valid(5 * FRAME + 10, cyc);
    total++; if (key_valid !== 1'b1) $display("FAIL press_valid got %b want 1", key_valid); else passed++;
    total++; if (cyc < 4 * FRAME || cyc > 5 * FRAME + 3)
      $display("FAIL press_latency got %0d want %0d..%0d", cyc, 4 * FRAME, 5 * FRAME + 3);
    else passed++;
    total++; if (key_code !== 4'd9) $display("FAIL press_code got %0d want 9", key_code); else passed++;
    total++; if (key_held !== 1'b1) $display("FAIL press_held got %b want 1", key_held); else passed++;
    repeat (10) tick();
    total++; if (key_valid !== 1'b1 || key_code !== 4'd9)
      $display("FAIL press_stall got valid=%b code=%0d want valid=1 code=9", key_valid, key_code);
    else passed++;
    key_ready = 1'b1;
    tick();
    total++; if (key_valid !== 1'b0) $display("FAIL press_accept got %b want 0", key_valid); else passed++;
    events = 0;
    repeat (5 * FRAME) begin tick(); if (key_valid) events++; end
    keys = '0;
    repeat (6 * FRAME) begin tick(); if (key_valid) events++; end
    total++; if (events !== 0) $display("FAIL press_single_event got %0d extra want 0", events); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL press_release_held got %b want 0", key_held); else passed++;
  endtask

  task automatic test_bounce();
    int cyc;
    int events;
    key_ready = 1'b1;
    events = 0;
    for (int i = 0; i < 10; i++) begin
      keys[9] = ~keys[9];
      repeat (20) begin tick(); if (key_valid) events++; end
    end
    total++; if (events !== 0) $display("FAIL bounce_quiet got %0d events want 0", events); else passed++;
    key_ready = 1'b0;
    keys[9] = 1'b1;
    wait_valid(6 * FRAME + 10, cyc);
    total++; if (key_valid !== 1'b1) $display("FAIL bounce_valid got %b want 1", key_valid); else passed++;
    total++; if (key_code !== 4'd9) $display("FAIL bounce_code got %0d want 9", key_code); else passed++;
    key_ready = 1'b1;
    tick();
    events = 0;
    repeat (5 * FRAME) begin tick(); if (key_valid) events++; end
    total++; if (events !== 0) $display("FAIL bounce_one_event got %0d extra want 0", events); else passed++;
    keys = '0;
    repeat (6 * FRAME) tick();
  endtask

  task automatic test_overrun();
    int cyc;
    int ovr;
    key_ready = 1'b0;
    keys = 16'h0001;
    wait_valid(6 * FRAME + 10, cyc);
    total++; if (key_valid !== 1'b1 || key_code !== 4'd0)
      $display("FAIL ovr_first got valid=%b code=%0d want valid=1 code=0", key_valid, key_code);
    else passed++;
    ovr = 0;
    keys = '0;
    repeat (6 * FRAME) begin tick(); if (overrun) ovr++; end
    keys = 16'h8000;
    repeat (6 * FRAME) begin tick(); if (overrun) ovr++; end
    total++; if (ovr !== 1) $display("FAIL ovr_pulses got %0d want 1", ovr); else passed++;
    total++; if (key_valid !== 1'b1) $display("FAIL ovr_valid_kept got %b want 1", key_valid); else passed++;
    total++; if (key_code !== 4'd0) $display("FAIL ovr_code_kept got %0d want 0", key_code); else passed++;
    total++; if (key_held !== 1'b1) $display("FAIL ovr_held got %b want 1", key_held); else passed++;
    key_ready = 1'b1;
    tick();
    total++; if (key_valid !== 1'b0) $display("FAIL ovr_accept got %b want 0", key_valid); else passed++;
    cyc = 0;
    repeat (3 * FRAME) begin tick(); if (key_valid) cyc++; end
    total++; if (cyc !== 0) $display("FAIL ovr_dropped got %0d cycles valid want 0", cyc); else passed++;
    keys = '0;
    repeat (6 * FRAME) tick();
  endtask

  task automatic test_multi();
    int cyc;
    int events;
    key_ready = 1'b1;
    keys = 16'h0060;
    events = 0;
    repeat (6 * FRAME) begin tick(); if (key_valid) events++; end
    total++; if (multi_key !== 1'b1) $display("FAIL multi_flag got %b want 1", multi_key); else passed++;
    total++; if (events !== 0) $display("FAIL multi_no_event got %0d events want 0", events); else passed++;
    key_ready = 1'b0;
    keys = 16'h0020;
    wait_valid(6 * FRAME + 10, cyc);
    total++; if (key_valid !== 1'b1) $display("FAIL multi_valid got %b want 1", key_valid); else passed++;
    total++; if (key_code !== 4'd5) $display("FAIL multi_code got %0d want 5", key_code); else passed++;
    total++; if (multi_key !== 1'b0) $display("FAIL multi_clear got %b want 0", multi_key); else passed++;
    key_ready = 1'b1;
    tick();
    keys = '0;
    repeat (6 * FRAME) tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    key_ready = 1'b0;
    keys = 16'h0200;
    wait_valid(6 * FRAME + 10, cyc);
    total++; if (key_valid !== 1'b1 || key_code !== 4'd9)
      $display("FAIL rmid_pre got valid=%b code=%0d want valid=1 code=9", key_valid, key_code);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (key_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", key_valid); else passed++;
    total++; if (key_code !== 4'd0) $display("FAIL rmid_code got %0d want 0", key_code); else passed++;
    total++; if (key_held !== 1'b0) $display("FAIL rmid_held got %b want 0", key_held); else passed++;
    total++; if (multi_key !== 1'b0) $display("FAIL rmid_multi got %b want 0", multi_key); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rmid_overrun got %b want 0", overrun); else passed++;
    total++; if (row_drive !== 4'b0001) $display("FAIL rmid_row got %b want 0001", row_drive); else passed++;
    wait_valid(6 * FRAME + 10, cyc);
    total++; if (key_valid !== 1'b1) $display("FAIL rmid_revalid got %b want 1", key_valid); else passed++;
    total++; if (key_code !== 4'd9) $display("FAIL rmid_recode got %0d want 9", key_code); else passed++;
    total++; if (cyc < 4 * FRAME) $display("FAIL rmid_debounce got %0d cycles want >= %0d", cyc, 4 * FRAME); else passed++;
    key_ready = 1'b1;
    tick();
    keys = '0;
    repeat (6 * FRAME) tick();
  endtask

  task automatic test_sweep();
    int cyc;
    for (int k = 0; k < 16; k++) begin
      keys2 = 16'd1 << k;
      cyc = 0;
      while (!key_valid2 && cyc < 5 * FRAME2) begin
        tick();
        cyc++;
      end
      total++; if (key_valid2 !== 1'b1 || key_code2 !== 4'(k))
        $display("FAIL sweep_key%0d got valid=%b code=%0d want valid=1 code=%0d",
                 k, key_valid2, key_code2, k);
      else passed++;
      tick();
      keys2 = '0;
      repeat (4 * FRAME2) tick();
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_single_press();
    test_bounce();
    test_overrun();
    test_multi();
    test_reset_mid();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
